vga_timing: RTL
===============

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter: H_VISIBLE, 1280, visible pixels per line.
REQ-002 Parameter: H_FP / H_SYNC / H_BP, 48 / 112 / 248, horizontal front porch / sync width / back porch in pixels.
REQ-003 Parameter: V_VISIBLE, 1024, visible lines per frame.
REQ-004 Parameter: V_FP / V_SYNC / V_BP, 1 / 3 / 38, vertical front porch / sync width / back porch in lines.
REQ-005 Port: CLK  in  1  pixel clock, 108 MHz; the block's one clock.
REQ-006 Port: RESETn  in  1  reset, asynchronous, active-low.
REQ-007 Port: hsync  out  1  horizontal sync, active high.
REQ-008 Port: vsync  out  1  vertical sync, active high.
REQ-009 Port: hdisp  out  1  horizontal display window.
REQ-010 Port: vdisp  out  1  vertical display window; consumed as an edge, so it is glitch-free.
REQ-011 Port: hpix  out  11  horizontal pixel counter.
REQ-012 Port: vpix  out  11  vertical line counter.
REQ-013 Port: frame_start  out  1  one-cycle pulse at position (0,0).
REQ-014 Port: line_start  out  1  one-cycle pulse at every hpix==0.

Function
REQ-015 Totals: HT = H_VISIBLE+H_FP+H_SYNC+H_BP (1688); VT = V_VISIBLE+V_FP+V_SYNC+V_BP (1066).
REQ-016 Running flag: clear in reset; set on the first CLK edge after RESETn deasserts; stays set until the next reset.
REQ-017 First edge: on the edge that sets running, outputs present position (0,0); no advance on that edge.
REQ-018 Advance: on every later edge, hpix increments; at HT-1 it wraps to 0.
REQ-019 Line step: vpix increments only on the edge where hpix wraps; at VT-1 it wraps to 0, which also wraps the frame.
REQ-020 Registered outputs: every output is a register, decoded from the same position the counters present on that cycle; zero latency between hpix/vpix and the flags.
REQ-021 hdisp = 1 iff hpix < H_VISIBLE.
REQ-022 vdisp = 1 iff vpix < V_VISIBLE.
REQ-023 hsync = 1 iff H_VISIBLE+H_FP <= hpix < H_VISIBLE+H_FP+H_SYNC, i.e. 1328..1439.
REQ-024 vsync = 1 iff V_VISIBLE+V_FP <= vpix < V_VISIBLE+V_FP+V_SYNC, i.e. 1025..1027.
REQ-025 Blanking values: hpix/vpix carry raw counts in blanking, never clamped.
REQ-026 Downstream gating: downstream gates pixels with hdisp&vdisp.
REQ-027 frame_start = 1 iff running and hpix==0 and vpix==0; line_start = 1 iff running and hpix==0.
REQ-028 vdisp edges: exactly one rising edge per frame, at (0,0); exactly one falling edge per frame, at (0,V_VISIBLE); no toggling within a line.
REQ-029 Frame period: exactly HT*VT = 1,799,408 CLK cycles.

Reset
REQ-030 Reset state: while RESETn=0, asynchronously: hpix=0, vpix=0, hdisp=0, vdisp=0, hsync=0, vsync=0, frame_start=0, line_start=0, running=0.
REQ-031 Reset mid-frame: reset abandons the frame immediately; the restart follows REQ-017 with no partial-line continuation.

Configuration
REQ-032 Macro VGA_TIMING_FRAMECNT_EN defined: adds output port frame_cnt (out, 16 bits, frame counter).
- Reset value 0.
- Increments on each frame_start after the first one; wraps from 65535 to 0.
REQ-033 Macro VGA_TIMING_FRAMECNT_EN undefined: port frame_cnt and its logic are absent; all other behaviour is identical.

Verification
REQ-034 Reset release: RESETn 0->1, first edge -> hpix=0, vpix=0, hdisp=1, vdisp=1, frame_start=1, line_start=1, hsync=0, vsync=0; next edge -> hpix=1, frame_start=0.
REQ-035 Horizontal timing: run one line -> hdisp falls when hpix goes 1279->1280; hsync high for hpix 1328..1439 (112 cycles); line_start period 1688.
REQ-036 Line and frame wrap:
- (1687,5) -> (0,6).
- (1687,1065) -> (0,0) with frame_start=1.
- vdisp low for vpix 1024..1065; vsync high for exactly 3 lines (5064 cycles).
- Check over 2 frames: frame_start spacing 1,799,408 cycles; vdisp exactly one rise and one fall per frame.
REQ-037 Mid-frame reset: RESETn=0 at (500,300) -> all outputs 0 before the next CLK edge; after release, restart per REQ-034.
REQ-038 Frame counter (macro defined): run 3 frames from reset -> frame_cnt 0,1,2; preload frame_cnt=65535 -> next frame_start gives 0.
REQ-039 Build check (macro undefined): elaboration shows no frame_cnt port; REQ-034..037 pass unchanged.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster position and sync/display flags produced by vga_timing.
// frame_cnt is present only when VGA_TIMING_FRAMECNT_EN is defined.
interface vga_timing_if;
  logic        hsync;
  logic        vsync;
  logic        hdisp;
  logic        vdisp;
  logic [10:0] hpix;
  logic [10:0] vpix;
  logic        frame_start;
  logic        line_start;
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_cnt;

  modport master (
    output hsync, vsync, hdisp, vdisp, hpix, vpix, frame_start, line_start, frame_cnt
  );
  modport slave (
    input hsync, vsync, hdisp, vdisp, hpix, vpix, frame_start, line_start, frame_cnt
  );
`else
  modport master (
    output hsync, vsync, hdisp, vdisp, hpix, vpix, frame_start, line_start
  );
  modport slave (
    input hsync, vsync, hdisp, vdisp, hpix, vpix, frame_start, line_start
  );
`endif
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters with registered sync/display/strobe flags.
// Define VGA_TIMING_FRAMECNT_EN to add the 16-bit frame_cnt output.
module vga_timing #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38
) (
  input  logic         CLK,
  input  logic         RESETn,
  vga_timing_if.master vga
);

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(HT - 1);
  localparam logic [10:0] V_LAST     = 11'(VT - 1);
  localparam logic [10:0] H_DISP_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_DISP_END = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] hpix;
  logic [10:0] vpix;
  logic [10:0] hpix_next;
  logic [10:0] vpix_next;
  logic        hsync;
  logic        vsync;
  logic        hdisp;
  logic        vdisp;
  logic        frame_start;
  logic        line_start;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // The edge leaving ST_IDLE presents (0,0) without advancing.
  always_comb begin
    state_next = ST_RUN;
    hpix_next  = '0;
    vpix_next  = '0;
    if (state == ST_RUN) begin
      if (hpix == H_LAST) begin
        hpix_next = '0;
        vpix_next = (vpix == V_LAST) ? 11'd0 : vpix + 11'd1;
      end else begin
        hpix_next = hpix + 11'd1;
        vpix_next = vpix;
      end
    end
  end

  // Flags decode the same next position the counters load, so they share its cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      hpix        <= '0;
      vpix        <= '0;
      hdisp       <= 1'b0;
      vdisp       <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      hpix        <= hpix_next;
      vpix        <= vpix_next;
      hdisp       <= (hpix_next < H_DISP_END);
      vdisp       <= (vpix_next < V_DISP_END);
      hsync       <= (hpix_next >= H_SYNC_BEG) && (hpix_next < H_SYNC_END);
      vsync       <= (vpix_next >= V_SYNC_BEG) && (vpix_next < V_SYNC_END);
      frame_start <= (hpix_next == 11'd0) && (vpix_next == 11'd0);
      line_start  <= (hpix_next == 11'd0);
    end
  end

  assign vga.hpix        = hpix;
  assign vga.vpix        = vpix;
  assign vga.hdisp       = hdisp;
  assign vga.vdisp       = vdisp;
  assign vga.hsync       = hsync;
  assign vga.vsync       = vsync;
  assign vga.frame_start = frame_start;
  assign vga.line_start  = line_start;

`ifdef VGA_TIMING_FRAMECNT_EN
  logic [15:0] frame_cnt;

  // The frame start produced by the first edge after reset is not counted.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      frame_cnt <= '0;
    end else if ((state == ST_RUN) && (hpix_next == 11'd0) && (vpix_next == 11'd0)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign vga.frame_cnt = frame_cnt;
`endif

endmodule
